// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter.
// Sends a start bit, DATA_BITS data bits LSB first, an optional parity bit
// and STOP_BITS stop bits. Each bit lasts one baud_tick period. Bytes come in
// through a valid/ready handshake. All outputs are registered.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Index of the final data bit and of the final stop bit.
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD_SENSE = 1'(PARITY_ODD);

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 parity_bit;

    // Frame sequencer: every state change and every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    // A tick seen in this cycle is deliberately not used: the
                    // frame waits in ALIGN so the start bit is a full period.
                    if (tx_valid && tx_ready) begin
                        shift      <= tx_data;
                        parity_bit <= (^tx_data) ^ ODD_SENSE;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= ALIGN;
                    end
                end

                ALIGN: begin
                    tx <= 1'b1;
                    if (baud_tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (baud_tick) begin
                        tx      <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            // shift[0] is on the line; shift[1] becomes next bit.
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                PARITY: begin
                    if (baud_tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end

                STOP: begin
                    tx <= 1'b1;
                    if (baud_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            tx_done  <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
